// File: rtl/rv32i_regfile_pkg.sv
// rtl/rv32i_regfile_pkg.sv - shared types and defaults for the multi-port register file
package rv32i_regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_XLEN_DEF = 32;
  localparam int RF_AW_DEF   = 5;
  localparam int RF_NRD_DEF  = 2;

endpackage

// File: rtl/rv32i_regfile_mp_if.sv
// rtl/rv32i_regfile_mp_if.sv - operand-fetch side bundle of the register file
interface rv32i_regfile_mp_if
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN_DEF,
  parameter int AW   = RF_AW_DEF,
  parameter int NRD  = RF_NRD_DEF
);

  logic                 stall;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD*XLEN-1:0]  rs_data;
  logic                 wr;
  logic [AW-1:0]        rd_addr;
  logic [XLEN-1:0]      rd_data;
  logic                 busy;

  modport master (
    output stall, rs_addr, wr, rd_addr, rd_data,
    input  rs_data, busy
  );

  modport slave (
    input  stall, rs_addr, wr, rd_addr, rd_data,
    output rs_data, busy
  );

endinterface

// File: rtl/rv32i_regfile_rdport.sv
// rtl/rv32i_regfile_rdport.sv - one read port: stall-held address register, bypass and x0 gating
module rv32i_regfile_rdport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [AW-1:0]   addr_in,
  output logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            byp_en,
  input  logic [AW-1:0]   byp_addr,
  input  logic [XLEN-1:0] byp_data,
  input  logic            force_zero,
  output logic [XLEN-1:0] data_out
);

  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
    end else if (!stall) begin
      raddr_q <= addr_in;
    end
  end

  assign raddr = raddr_q;

  // x0 and the clear window override both the array and the forwarded write
  always_comb begin
    data_out = arr_data;
    if (BYPASS && byp_en && (byp_addr == raddr_q)) begin
      data_out = byp_data;
    end
    if (force_zero || (ZERO_REG && (raddr_q == '0))) begin
      data_out = '0;
    end
  end

endmodule

// File: rtl/rv32i_regfile_mp.sv
// rtl/rv32i_regfile_mp.sv - parametrised multi-read-port register file with hardware clear
module rv32i_regfile_mp
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEF,
  parameter int AW       = RF_AW_DEF,
  parameter int NRD      = RF_NRD_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  rv32i_regfile_mp_if.slave rf
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            busy;
  logic            wr_ok;

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]       raddr     [NRD];
  logic [XLEN-1:0]     arr_rd    [NRD];
  logic [XLEN-1:0]     port_data [NRD];
  logic [NRD*XLEN-1:0] rs_data_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // writes to x0 are dropped here so the array never holds a stale x0 value
  assign wr_ok = rf.wr && (state_q == RF_READY) && !(ZERO_REG && (rf.rd_addr == '0));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = rf.rd_addr;
    mem_wdata = rf.rd_data;
    busy      = 1'b1;
    if (state_q == RF_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST) begin
        state_d = RF_READY;
      end
    end else begin
      busy   = 1'b0;
      mem_we = wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    assign arr_rd[k] = mem[raddr[k]];

    rv32i_regfile_rdport #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .clk        (clk),
      .rst        (rst),
      .stall      (rf.stall),
      .addr_in    (rf.rs_addr[k*AW +: AW]),
      .raddr      (raddr[k]),
      .arr_data   (arr_rd[k]),
      .byp_en     (wr_ok),
      .byp_addr   (rf.rd_addr),
      .byp_data   (rf.rd_data),
      .force_zero (busy),
      .data_out   (port_data[k])
    );
  end

  always_comb begin
    rs_data_w = '0;
    for (int k = 0; k < NRD; k++) begin
      rs_data_w[k*XLEN +: XLEN] = port_data[k];
    end
  end

  assign rf.rs_data = rs_data_w;
  assign rf.busy    = busy;

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// tb/tb_rv32i_regfile_mp.sv - directed bench for the register file, bypass and non-bypass builds
module tb_rv32i_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2)) rf_b ();
  rv32i_regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2)) rf_n ();

  assign rf_n.stall   = rf_b.stall;
  assign rf_n.rs_addr = rf_b.rs_addr;
  assign rf_n.wr      = rf_b.wr;
  assign rf_n.rd_addr = rf_b.rd_addr;
  assign rf_n.rd_data = rf_b.rd_data;

  rv32i_regfile_mp #(.XLEN(32), .AW(5), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .rf  (rf_b)
  );

  rv32i_regfile_mp #(.XLEN(32), .AW(5), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .rf  (rf_n)
  );

  wire [31:0] b_p0 = rf_b.rs_data[31:0];
  wire [31:0] b_p1 = rf_b.rs_data[63:32];
  wire [31:0] n_p0 = rf_n.rs_data[31:0];
  wire [31:0] n_p1 = rf_n.rs_data[63:32];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
    rf_b.rs_addr = {a1, a0};
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    rf_b.wr = 1'b1;
    rf_b.rd_addr = a;
    rf_b.rd_data = d;
    tick();
    rf_b.wr = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    logic bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (rf_b.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 1", rf_b.busy);
    end
    cnt = 0;
    bad = 1'b0;
    for (int i = 0; i < 40 && rf_b.busy === 1'b1; i++) begin
      cnt++;
      if (b_p0 !== 32'h0 || b_p1 !== 32'h0 || n_p0 !== 32'h0 || n_p1 !== 32'h0) bad = 1'b1;
      tick();
    end
    n_chk++;
    if (cnt != 32) begin
      n_fail++; $display("FAIL reset_busy_len: got %0d cycles expected 32", cnt);
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdata_zero: got nonzero read data expected 0 while busy");
    end
    n_chk++;
    if (rf_n.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_nbyp: got %b expected 0", rf_n.busy);
    end
    for (int a = 0; a < 32; a++) begin
      set_rs(5'(a), 5'(31 - a));
      tick();
      n_chk++;
      if (b_p0 !== 32'h0 || b_p1 !== 32'h0 || n_p0 !== 32'h0 || n_p1 !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_sweep a=%0d: got %h %h %h %h expected all 0", a, b_p0, b_p1, n_p0, n_p1);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'hDEADBEEF);
    set_rs(5'd5, 5'd6);
    tick();
    n_chk++;
    if (b_p0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_rd_p0: got %h expected deadbeef", b_p0);
    end
    n_chk++;
    if (b_p1 !== 32'h0) begin
      n_fail++; $display("FAIL wr_rd_p1: got %h expected 0", b_p1);
    end
    n_chk++;
    if (n_p0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_rd_nbyp_p0: got %h expected deadbeef", n_p0);
    end
  endtask

  task automatic test_bypass();
    set_rs(5'd5, 5'd7);
    tick();
    rf_b.wr = 1'b1;
    rf_b.rd_addr = 5'd7;
    rf_b.rd_data = 32'h12345678;
    #1;
    n_chk++;
    if (b_p1 !== 32'h12345678) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected 12345678", b_p1);
    end
    n_chk++;
    if (n_p1 !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_old_value: got %h expected 0", n_p1);
    end
    n_chk++;
    if (b_p0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_other_port: got %h expected deadbeef", b_p0);
    end
    tick();
    rf_b.wr = 1'b0;
    #1;
    n_chk++;
    if (n_p1 !== 32'h12345678 || b_p1 !== 32'h12345678) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %h %h expected 12345678", b_p1, n_p1);
    end
  endtask

  task automatic test_x0();
    set_rs(5'd0, 5'd0);
    tick();
    rf_b.wr = 1'b1;
    rf_b.rd_addr = 5'd0;
    rf_b.rd_data = 32'hFFFFFFFF;
    #1;
    n_chk++;
    if (b_p0 !== 32'h0 || b_p1 !== 32'h0 || n_p0 !== 32'h0) begin
      n_fail++; $display("FAIL x0_bypass: got %h %h %h expected 0", b_p0, b_p1, n_p0);
    end
    tick();
    rf_b.wr = 1'b0;
    #1;
    n_chk++;
    if (b_p0 !== 32'h0 || b_p1 !== 32'h0 || n_p1 !== 32'h0) begin
      n_fail++; $display("FAIL x0_after_write: got %h %h %h expected 0", b_p0, b_p1, n_p1);
    end
  endtask

  task automatic test_stall();
    write_reg(5'd3, 32'hA5A50003);
    write_reg(5'd9, 32'h09090909);
    set_rs(5'd3, 5'd3);
    tick();
    n_chk++;
    if (b_p0 !== 32'hA5A50003) begin
      n_fail++; $display("FAIL stall_setup: got %h expected a5a50003", b_p0);
    end
    rf_b.stall = 1'b1;
    set_rs(5'd9, 5'd9);
    tick();
    n_chk++;
    if (b_p0 !== 32'hA5A50003 || b_p1 !== 32'hA5A50003) begin
      n_fail++; $display("FAIL stall_hold1: got %h %h expected a5a50003", b_p0, b_p1);
    end
    tick();
    n_chk++;
    if (n_p0 !== 32'hA5A50003 || n_p1 !== 32'hA5A50003) begin
      n_fail++; $display("FAIL stall_hold2: got %h %h expected a5a50003", n_p0, n_p1);
    end
    rf_b.stall = 1'b0;
    #1;
    n_chk++;
    if (b_p0 !== 32'hA5A50003) begin
      n_fail++; $display("FAIL stall_release_pre: got %h expected a5a50003", b_p0);
    end
    tick();
    n_chk++;
    if (b_p0 !== 32'h09090909 || b_p1 !== 32'h09090909) begin
      n_fail++; $display("FAIL stall_release: got %h %h expected 09090909", b_p0, b_p1);
    end
  endtask

  task automatic test_back_to_back();
    write_reg(5'd10, 32'h00000001);
    write_reg(5'd11, 32'h80000000);
    write_reg(5'd12, 32'h7FFFFFFF);
    write_reg(5'd13, 32'h5555AAAA);
    write_reg(5'd31, 32'hC0FFEE31);
    set_rs(5'd10, 5'd11);
    tick();
    n_chk++;
    if (b_p0 !== 32'h00000001 || b_p1 !== 32'h80000000) begin
      n_fail++; $display("FAIL b2b_10_11: got %h %h expected 00000001 80000000", b_p0, b_p1);
    end
    set_rs(5'd13, 5'd12);
    tick();
    n_chk++;
    if (n_p0 !== 32'h5555AAAA || n_p1 !== 32'h7FFFFFFF) begin
      n_fail++; $display("FAIL b2b_13_12: got %h %h expected 5555aaaa 7fffffff", n_p0, n_p1);
    end
    set_rs(5'd31, 5'd31);
    tick();
    n_chk++;
    if (b_p0 !== 32'hC0FFEE31 || b_p1 !== 32'hC0FFEE31) begin
      n_fail++; $display("FAIL b2b_top_entry: got %h %h expected c0ffee31", b_p0, b_p1);
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    logic bad;
    set_rs(5'd5, 5'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (rf_b.busy !== 1'b1) bad = 1'b1;
      tick();
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL midclear_busy_pre: got busy low expected 1");
    end
    rst = 1'b1;
    rf_b.wr = 1'b1;
    rf_b.rd_addr = 5'd5;
    rf_b.rd_data = 32'hCAFEF00D;
    tick();
    rst = 1'b0;
    cnt = 0;
    bad = 1'b0;
    for (int i = 0; i < 40 && rf_b.busy === 1'b1; i++) begin
      cnt++;
      if (b_p0 !== 32'h0 || b_p1 !== 32'h0) bad = 1'b1;
      tick();
    end
    rf_b.wr = 1'b0;
    n_chk++;
    if (cnt != 32) begin
      n_fail++; $display("FAIL midclear_busy_len: got %0d cycles expected 32", cnt);
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL midclear_rdata: got nonzero read data expected 0 while busy");
    end
    set_rs(5'd5, 5'd9);
    tick();
    n_chk++;
    if (b_p0 !== 32'h0 || b_p1 !== 32'h0 || n_p0 !== 32'h0) begin
      n_fail++; $display("FAIL midclear_cleared: got %h %h %h expected 0", b_p0, b_p1, n_p0);
    end
  endtask

  initial begin
    rst = 1'b1;
    rf_b.stall = 1'b0;
    rf_b.rs_addr = '0;
    rf_b.wr = 1'b0;
    rf_b.rd_addr = '0;
    rf_b.rd_data = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_stall();
    test_back_to_back();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
